// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the fetch path, the load/store path and the unified memory port.
// The slave modport is the arbiter's view; master is the core-plus-memory side.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = 4;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [BE_WIDTH-1:0]   d_be;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_valid;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data has priority; a bounded data streak guarantees fetch progress.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 2
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned BE_WIDTH = 4;
  localparam int unsigned SW       = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_owner_d;
  logic [SW-1:0]         r_streak;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [BE_WIDTH-1:0]   r_mem_be;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic                  r_if_valid;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_d_valid;

  logic w_any_req;
  logic w_grant_d;

  // Data wins a tie unless it has already used up its streak allowance.
  assign w_any_req = bus.if_req | bus.d_req;
  assign w_grant_d = bus.d_req & (~bus.if_req | (r_streak != STREAK_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner_d   <= 1'b0;
      r_streak    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state   <= ST_BUSY;
            r_mem_req <= 1'b1;
            if (w_grant_d) begin
              r_owner_d   <= 1'b1;
              r_mem_we    <= bus.d_we;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
              r_mem_be    <= bus.d_be;
              if (!bus.if_req) begin
                r_streak <= '0;
              end else if (r_streak != STREAK_MAX) begin
                r_streak <= r_streak + SW'(1);
              end
            end else begin
              r_owner_d  <= 1'b0;
              r_mem_we   <= 1'b0;
              r_mem_addr <= bus.if_addr;
              r_mem_be   <= '0;
              r_streak   <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (bus.mem_ready) begin
            r_state   <= ST_RESP;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= '0;
            if (r_owner_d) begin
              r_d_rdata <= r_mem_we ? '0 : bus.mem_rdata;
              r_d_valid <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_valid <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_mem_be  <= '0;
        end
      endcase
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level arbitration and memory model.
module tb_mem_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned MAXS = 2;

  logic clk;
  logic rst;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Memory model controls
  int          mem_wait_cfg   = 0;
  bit          mem_rand       = 0;
  bit          mem_force      = 0;
  logic [31:0] mem_force_data = 32'h0;
  int          mem_cnt        = 0;
  int          mem_target     = 0;
  bit          mem_prev       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory answers after a chosen number of wait cycles; tolerates dropped requests.
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      if (!mem_prev) begin
        mem_cnt    = 0;
        mem_target = mem_rand ? int'($urandom_range(0, 3)) : mem_wait_cfg;
      end else begin
        mem_cnt++;
      end
      bus.mem_ready = (mem_cnt >= mem_target);
      bus.mem_rdata = mem_force ? mem_force_data : mem_fn(bus.mem_addr);
      mem_prev      = 1'b1;
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      mem_prev      = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_be    = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    mem_force    = 1'b0;
    mem_rand     = 1'b0;
    mem_wait_cfg = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    step();
    step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'h0) begin
      errors++;
      $display("FAIL reset_mem_ctrl: got req=%0b we=%0b be=%h want 0", bus.mem_req, bus.mem_we, bus.mem_be);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata} !== 66'h0) begin
      errors++;
      $display("FAIL reset_resp: got ifv=%0b dv=%0b ifr=%h dr=%h want 0",
               bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL reset_first_grant: got req=%0b addr=%h want 1 00000040", bus.mem_req, bus.mem_addr);
    end
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== mem_fn(32'h40)) begin
      errors++;
      $display("FAIL reset_first_resp: got v=%0b data=%h want 1 %h", bus.if_valid, bus.if_rdata, mem_fn(32'h40));
    end
    bus.if_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_single_fetch();
    do_reset();
    mem_force      = 1'b1;
    mem_force_data = 32'h0050_0093;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h10;
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin
      errors++;
      $display("FAIL fetch_issue: got req=%0b addr=%h we=%0b be=%h want 1 00000010 0 0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be);
    end
    checks++;
    if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_early_valid: got ifv=%0b dv=%0b want 0 0", bus.if_valid, bus.d_valid);
    end
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0050_0093 || bus.d_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp: got ifv=%0b data=%h dv=%0b req=%0b want 1 00500093 0 0",
               bus.if_valid, bus.if_rdata, bus.d_valid, bus.mem_req);
    end
    bus.if_req = 1'b0;
    step();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_rdata !== 32'h0050_0093 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_after: got ifv=%0b data=%h req=%0b want 0 00500093 0",
               bus.if_valid, bus.if_rdata, bus.mem_req);
    end
    step();
    mem_force = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    mem_force      = 1'b1;
    mem_force_data = 32'hCAFE_F00D;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h14;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b1;
    bus.d_addr     = 32'h100;
    bus.d_wdata    = 32'hDEAD_BEEF;
    bus.d_be       = 4'hF;
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'hF ||
        bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL simul_store_issue: got req=%0b we=%0b be=%h wd=%h addr=%h want 1 1 f deadbeef 00000100",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
    end
    step();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_store_resp: got dv=%0b dr=%h ifv=%0b want 1 0 0", bus.d_valid, bus.d_rdata, bus.if_valid);
    end
    bus.d_req = 1'b0;
    step();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin
      errors++;
      $display("FAIL simul_gap: got req=%0b we=%0b be=%h want 0 0 0", bus.mem_req, bus.mem_we, bus.mem_be);
    end
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h14 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin
      errors++;
      $display("FAIL simul_fetch_issue: got req=%0b addr=%h we=%0b be=%h want 1 00000014 0 0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be);
    end
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hCAFE_F00D || bus.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_fetch_resp: got ifv=%0b data=%h dv=%0b want 1 cafef00d 0",
               bus.if_valid, bus.if_rdata, bus.d_valid);
    end
    bus.if_req = 1'b0;
    step();
    step();
    mem_force = 1'b0;
  endtask

  task automatic test_starvation();
    string       got;
    string       want;
    int          sm     = 0;
    int          grants = 0;
    bit          pm     = 1'b0;
    logic [31:0] a      = 32'h1000;
    got  = "";
    want = "";
    // Both requesters always pending: data wins until its streak allowance is exhausted.
    for (int i = 0; i < 6; i++) begin
      if (sm != int'(MAXS)) begin
        want = {want, "D"};
        sm   = (sm + 1 > int'(MAXS)) ? int'(MAXS) : sm + 1;
      end else begin
        want = {want, "I"};
        sm   = 0;
      end
    end
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h2000;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = a;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      step();
      if (bus.mem_req === 1'b1 && !pm) begin
        got = {got, (bus.mem_addr === 32'h2000) ? "I" : "D"};
        grants++;
      end
      pm = (bus.mem_req === 1'b1);
      if (bus.d_valid === 1'b1) begin
        a          = a + 32'h4;
        bus.d_addr = a;
      end
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL starvation_order: got %s want %s", got, want);
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_wait_states();
    do_reset();
    mem_force      = 1'b1;
    mem_force_data = 32'h1234_5678;
    mem_wait_cfg   = 3;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b0;
    bus.d_addr     = 32'h200;
    bus.d_be       = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.d_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_busy_c%0d: got req=%0b addr=%h dv=%0b want 1 00000200 0",
                 c, bus.mem_req, bus.mem_addr, bus.d_valid);
      end
    end
    step();
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h1234_5678 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_resp: got dv=%0b dr=%h req=%0b want 1 12345678 0", bus.d_valid, bus.d_rdata, bus.mem_req);
    end
    bus.d_req = 1'b0;
    step();
    checks++;
    if (bus.d_valid !== 1'b0 || bus.d_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wait_after: got dv=%0b dr=%h want 0 12345678", bus.d_valid, bus.d_rdata);
    end
    step();
    mem_force    = 1'b0;
    mem_wait_cfg = 0;
  endtask

  task automatic test_reset_mid_busy();
    int spurious = 0;
    do_reset();
    mem_wait_cfg = 10;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h30;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop: got req=%0b ifv=%0b want 0 0", bus.mem_req, bus.if_valid);
    end
    rst        = 1'b0;
    bus.if_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d active cycles want 0", spurious);
    end
    mem_wait_cfg = 0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h34;
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h34) begin
      errors++;
      $display("FAIL midrst_regrant: got req=%0b addr=%h want 1 00000034", bus.mem_req, bus.mem_addr);
    end
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== mem_fn(32'h34)) begin
      errors++;
      $display("FAIL midrst_resp: got v=%0b data=%h want 1 %h", bus.if_valid, bus.if_rdata, mem_fn(32'h34));
    end
    bus.if_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_random();
    bit          if_pend = 0, d_pend = 0;
    logic [31:0] if_a = 0, d_a = 0, d_wd = 0;
    logic        d_w  = 0;
    logic [3:0]  d_b  = 0;
    int          sm   = 0;
    int          owner = 0;
    bit          p_if = 0, p_d = 0, p_mreq = 0;
    int          done = 0;
    bit          exp_d;
    do_reset();
    mem_rand = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (bus.mem_req === 1'b1 && !p_mreq) begin
        exp_d = p_d && (!p_if || sm != int'(MAXS));
        checks++;
        if (!(p_if || p_d) || owner != 0) begin
          errors++;
          $display("FAIL rand_spurious_grant c%0d: got grant with if=%0b d=%0b owner=%0d want pending req, idle port",
                   c, p_if, p_d, owner);
        end
        if (exp_d) sm = p_if ? ((sm + 1 > int'(MAXS)) ? int'(MAXS) : sm + 1) : 0;
        else       sm = 0;
        owner = exp_d ? 2 : 1;
        checks++;
        if (exp_d) begin
          if (bus.mem_we !== d_w || bus.mem_addr !== d_a || bus.mem_be !== d_b ||
              (d_w && bus.mem_wdata !== d_wd)) begin
            errors++;
            $display("FAIL rand_d_grant c%0d: got we=%0b addr=%h be=%h wd=%h want %0b %h %h %h",
                     c, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, d_w, d_a, d_b, d_wd);
          end
        end else begin
          if (bus.mem_we !== 1'b0 || bus.mem_addr !== if_a || bus.mem_be !== 4'h0) begin
            errors++;
            $display("FAIL rand_if_grant c%0d: got we=%0b addr=%h be=%h want 0 %h 0",
                     c, bus.mem_we, bus.mem_addr, bus.mem_be, if_a);
          end
        end
      end
      if (bus.if_valid === 1'b1 || bus.d_valid === 1'b1) begin
        checks++;
        if (bus.if_valid === 1'b1 && bus.d_valid === 1'b1) begin
          errors++;
          $display("FAIL rand_dual_valid c%0d: got both valids high want one", c);
        end
      end
      if (bus.if_valid === 1'b1) begin
        checks++;
        if (owner != 1 || bus.if_rdata !== mem_fn(if_a)) begin
          errors++;
          $display("FAIL rand_if_resp c%0d: got owner=%0d data=%h want 1 %h", c, owner, bus.if_rdata, mem_fn(if_a));
        end
        if_pend = 0;
        owner   = 0;
        done++;
      end else if (bus.d_valid === 1'b1) begin
        checks++;
        if (owner != 2 || bus.d_rdata !== (d_w ? 32'h0 : mem_fn(d_a))) begin
          errors++;
          $display("FAIL rand_d_resp c%0d: got owner=%0d data=%h want 2 %h",
                   c, owner, bus.d_rdata, d_w ? 32'h0 : mem_fn(d_a));
        end
        d_pend = 0;
        owner  = 0;
        done++;
      end
      p_mreq = (bus.mem_req === 1'b1);
      if (!if_pend) begin
        if ($urandom_range(0, 1) == 0) begin
          if_pend     = 1;
          if_a        = {$urandom_range(0, 32'hFFFF), 2'b00};
          bus.if_addr = if_a;
        end
        bus.if_req = if_pend;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          d_pend      = 1;
          d_w         = 1'($urandom_range(0, 1));
          d_a         = $urandom;
          d_wd        = $urandom;
          d_b         = 4'($urandom_range(0, 15));
          bus.d_we    = d_w;
          bus.d_addr  = d_a;
          bus.d_wdata = d_wd;
          bus.d_be    = d_b;
        end
        bus.d_req = d_pend;
      end
      p_if = bus.if_req;
      p_d  = bus.d_req;
    end
    checks++;
    if (done < 50) begin
      errors++;
      $display("FAIL rand_progress: got %0d completions want at least 50", done);
    end
    clear_inputs();
    mem_rand = 1'b0;
    for (int c = 0; c < 8; c++) step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
